// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter
// Two-requester round-robin arbiter and sequencer for one single-port
// synchronous RAM with 1-cycle read latency. Each accepted request is
// granted for exactly one cycle. During that cycle the RAM pins are driven.
// A read is followed by one WAIT cycle, and its result is then returned
// through the shared rdata register with a one-cycle rvalid pulse.
//
// Ports:
//   clk                          system clock, rising edge
//   rst_n                        synchronous active-low reset
//   req0/we0/addr0/wdata0        requester 0 request, held until gnt0
//   req1/we1/addr1/wdata1        requester 1 request, held until gnt1
//   gnt0/gnt1                    one-cycle grant pulses
//   rvalid0/rvalid1              one-cycle read-result pulses
//   rdata                        last read value
//   busy                         high while the sequencer is not idle
//   ram_we/ram_addr/ram_wdata    RAM control outputs
//   ram_rdata                    RAM read data, one cycle after ram_addr
module mem_access_arbiter #(
  parameter int AW = 4,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] GRANT = 2'b01;
  localparam logic [1:0] WAIT  = 2'b10;

  logic [1:0] state;
  logic       last;      // requester granted most recently
  logic       owner;     // requester served by the current access
  logic       we_reg;    // registered write enable
  logic       any_req;
  logic       pick1;

  // Round-robin choice: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    any_req = req0 | req1;
    pick1   = req1 & (~req0 | ~last);
  end

  // The write strobe is qualified by rst_n, so a reset that lands in the GRANT
  // cycle also blocks the write the RAM would otherwise commit on that edge.
  assign ram_we = we_reg & rst_n;

  // Sequencer state, round-robin pointer and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= 1'b1;
      owner     <= 1'b0;
      we_reg    <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      rdata     <= '0;
      busy      <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      // Pulses default low and are raised only in the state that owns them.
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state     <= GRANT;
            busy      <= 1'b1;
            owner     <= pick1;
            last      <= pick1;
            gnt0      <= ~pick1;
            gnt1      <= pick1;
            we_reg    <= pick1 ? we1 : we0;
            ram_addr  <= pick1 ? addr1 : addr0;
            ram_wdata <= pick1 ? wdata1 : wdata0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        GRANT: begin
          // A write commits on this edge. A read needs one more cycle for RAM data.
          we_reg <= 1'b0;
          if (we_reg) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= WAIT;
            busy  <= 1'b1;
          end
        end
        WAIT: begin
          state   <= IDLE;
          busy    <= 1'b0;
          rdata   <= ram_rdata;
          rvalid0 <= ~owner;
          rvalid1 <= owner;
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          we_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb_mem_access_arbiter
// Directed stimulus for mem_access_arbiter with a behavioural 16x4 RAM.
// Stimulus pushes the expected grants and read results into queues. A monitor
// running on the falling edge pops and compares whenever the DUT pulses gnt or
// rvalid.
module tb_mem_access_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0, we0, req1, we1;
  logic [3:0] addr0, wdata0, addr1, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1, busy, ram_we;
  logic [3:0] rdata, ram_addr, ram_wdata, ram_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int gcyc [2];

  typedef struct {
    int         who;
    logic       we;
    logic [3:0] addr;
    logic [3:0] wdata;
  } gexp_t;

  typedef struct {
    int         who;
    logic [3:0] data;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];

  mem_access_arbiter #(.AW(4), .DW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .busy(busy),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural RAM. Its contents are preloaded on the first edge.
  logic [3:0] mem [16];
  bit         mem_loaded = 1'b0;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 16; i++) mem[i] <= 4'(i);
      mem[1]     <= 4'h3;
      mem[2]     <= 4'hC;
      mem[7]     <= 4'h9;
      mem_loaded <= 1'b1;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_g(input int who, input logic w, input logic [3:0] a, input logic [3:0] d);
    gexp_t e;
    e.who = who; e.we = w; e.addr = a; e.wdata = d;
    gq.push_back(e);
  endtask

  task automatic push_r(input int who, input logic [3:0] d);
    rexp_t e;
    e.who = who; e.data = d;
    rq.push_back(e);
  endtask

  // Monitor: checks every grant and read-result pulse against the queues.
  always @(negedge clk) begin
    if (gnt0 === 1'b1 || gnt1 === 1'b1) begin
      chk("gnt_exclusive", int'(gnt0 & gnt1), 0);
      if (gq.size() == 0) begin
        chk("unexpected_gnt", 1, 0);
      end else begin
        gexp_t e;
        int    who;
        e   = gq.pop_front();
        who = (gnt1 === 1'b1) ? 1 : 0;
        chk("gnt_who", who, e.who);
        chk("gnt_ram_we", int'(ram_we), int'(e.we));
        chk("gnt_ram_addr", int'(ram_addr), int'(e.addr));
        chk("gnt_ram_wdata", int'(ram_wdata), int'(e.wdata));
        chk("gnt_busy", int'(busy), 1);
        gcyc[who] = cyc;
      end
    end
    if (rvalid0 === 1'b1 || rvalid1 === 1'b1) begin
      chk("rvalid_exclusive", int'(rvalid0 & rvalid1), 0);
      if (rq.size() == 0) begin
        chk("unexpected_rvalid", 1, 0);
      end else begin
        rexp_t e;
        int    who;
        e   = rq.pop_front();
        who = (rvalid1 === 1'b1) ? 1 : 0;
        chk("rvalid_who", who, e.who);
        chk("rdata", int'(rdata), int'(e.data));
        chk("rvalid_latency", cyc - gcyc[who], 2);
      end
    end
  end

  // One complete request: raise req, wait (bounded) for gnt, drop at the end of gnt.
  task automatic xact(input int id, input logic w, input logic [3:0] a, input logic [3:0] d);
    bit got = 1'b0;
    if (id == 0) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
    else         begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
    for (int n = 0; n < 40 && !got; n++) begin
      @(posedge clk); #1;
      got = (id == 0) ? gnt0 : gnt1;
    end
    if (!got) chk("gnt_timeout", 0, 1);
    @(posedge clk); #1;
    if (id == 0) req0 = 1'b0;
    else         req1 = 1'b0;
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_gnt0"}, int'(gnt0), 0);
    chk({tag, "_gnt1"}, int'(gnt1), 0);
    chk({tag, "_rvalid0"}, int'(rvalid0), 0);
    chk({tag, "_rvalid1"}, int'(rvalid1), 0);
    chk({tag, "_rdata"}, int'(rdata), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_ram_we"}, int'(ram_we), 0);
    chk({tag, "_ram_addr"}, int'(ram_addr), 0);
    chk({tag, "_ram_wdata"}, int'(ram_wdata), 0);
  endtask

  initial begin
    bit got;
    // Reset held for two cycles with both requests pending.
    rst_n = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 4'h1; wdata0 = 4'h0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 4'h2; wdata1 = 4'h0;
    repeat (2) begin
      @(posedge clk); #1;
      idle_chk("reset");
    end

    // Continuous reads from both requesters: requester 0 first, then strict alternation.
    push_g(0, 1'b0, 4'h1, 4'h0); push_g(1, 1'b0, 4'h2, 4'h0);
    push_g(0, 1'b0, 4'h1, 4'h0); push_g(1, 1'b0, 4'h2, 4'h0);
    push_r(0, 4'h3); push_r(1, 4'hC); push_r(0, 4'h3); push_r(1, 4'hC);
    rst_n = 1'b1;
    fork
      begin xact(0, 1'b0, 4'h1, 4'h0); xact(0, 1'b0, 4'h1, 4'h0); end
      begin xact(1, 1'b0, 4'h2, 4'h0); xact(1, 1'b0, 4'h2, 4'h0); end
    join
    repeat (4) @(posedge clk); #1;

    // Single write, then read back from the same address.
    push_g(0, 1'b1, 4'h5, 4'hA);
    push_g(0, 1'b0, 4'h5, 4'h0);
    push_r(0, 4'hA);
    xact(0, 1'b1, 4'h5, 4'hA);
    xact(0, 1'b0, 4'h5, 4'h0);
    repeat (4) @(posedge clk); #1;

    // Requester 1 served alone, then a tie goes to requester 0.
    push_g(1, 1'b0, 4'h2, 4'h0); push_r(1, 4'hC);
    xact(1, 1'b0, 4'h2, 4'h0);
    push_g(0, 1'b0, 4'h1, 4'h0); push_g(1, 1'b0, 4'h2, 4'h0);
    push_r(0, 4'h3); push_r(1, 4'hC);
    fork
      xact(0, 1'b0, 4'h1, 4'h0);
      xact(1, 1'b0, 4'h2, 4'h0);
    join
    repeat (4) @(posedge clk); #1;

    // Reset in the WAIT cycle of a read: the result is discarded.
    push_g(0, 1'b0, 4'h5, 4'h0);
    xact(0, 1'b0, 4'h5, 4'h0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("wait_rst_rdata", int'(rdata), 0);
    chk("wait_rst_rvalid0", int'(rvalid0), 0);
    chk("wait_rst_busy", int'(busy), 0);
    @(posedge clk); #1;
    chk("wait_rst_rvalid0_next", int'(rvalid0), 0);
    chk("wait_rst_busy_next", int'(busy), 0);

    // Reset in the GRANT cycle of a write to 7. The write strobe is already
    // masked during that cycle, so a later read returns the old value 9.
    push_g(0, 1'b0, 4'h7, 4'h5);
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'h7; wdata0 = 4'h5;
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(posedge clk); #1;
      got = gnt0;
    end
    if (!got) chk("grant_rst_timeout", 0, 1);
    rst_n = 1'b0;
    req0  = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("grant_rst_gnt0", int'(gnt0), 0);
    chk("grant_rst_ram_we", int'(ram_we), 0);
    push_g(1, 1'b0, 4'h7, 4'h0); push_r(1, 4'h9);
    xact(1, 1'b0, 4'h7, 4'h0);
    repeat (4) @(posedge clk); #1;

    // Back-to-back: requester 1 writes F=6, then requester 0 reads F.
    push_g(1, 1'b1, 4'hF, 4'h6);
    push_g(0, 1'b0, 4'hF, 4'h0);
    push_r(0, 4'h6);
    xact(1, 1'b1, 4'hF, 4'h6);
    xact(0, 1'b0, 4'hF, 4'h0);
    repeat (6) @(posedge clk); #1;

    chk("grants_outstanding", gq.size(), 0);
    chk("reads_outstanding", rq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
